// File: rtl/snail_scan_arbiter.sv
// snail_scan_arbiter: round-robin shared MSB-first scan counting overlapping 3-bit pattern matches (in: clk rst req data0 data1 pat; out: gnt busy hit done done_id cnt)
module snail_scan_arbiter #(
  parameter int W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [W-1:0]     data0,
  input  logic [W-1:0]     data1,
  input  logic [2:0]       pat,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             hit,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] cnt
);
  localparam int BW = $clog2(W);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, FLUSH = 3'd3, DONE = 3'd4;
  logic [2:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic lp_q, lp_d;
  logic [W-1:0] sr_q, sr_d;
  logic [2:0] pat_q, pat_d, win_q, win_d, win_n;
  logic [1:0] vc_q, vc_d, vc_n;
  logic [BW-1:0] bc_q, bc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hit_q, match;
  assign win_n = {win_q[1:0], sr_q[W-1]};
  assign vc_n = vc_q == 2'd3 ? 2'd3 : vc_q + 2'd1;
  assign match = state_q == SHIFT && win_n == pat_q && vc_n == 2'd3;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    lp_d = lp_q;
    sr_d = sr_q;
    pat_d = pat_q;
    win_d = win_q;
    vc_d = vc_q;
    bc_d = bc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = |req ? LOAD : IDLE;
        gnt_d = ~|req ? 2'b00 : (req[1] && (!req[0] || !lp_q)) ? 2'b10 : 2'b01;
      end
      LOAD: begin
        state_d = SHIFT;
        sr_d = gnt_q[1] ? data1 : data0;
        pat_d = pat;
        win_d = '0;
        vc_d = '0;
        bc_d = '0;
        cnt_d = '0;
        lp_d = gnt_q[1];
      end
      SHIFT: begin
        state_d = bc_q == BW'(W - 1) ? FLUSH : SHIFT;
        sr_d = sr_q << 1;
        win_d = win_n;
        vc_d = vc_n;
        bc_d = bc_q + 1'b1;
        cnt_d = cnt_q + CNT_W'(match && !(&cnt_q));
      end
      FLUSH: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        gnt_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      lp_q <= 1'b1;
      sr_q <= '0;
      pat_q <= '0;
      win_q <= '0;
      vc_q <= '0;
      bc_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      lp_q <= lp_d;
      sr_q <= sr_d;
      pat_q <= pat_d;
      win_q <= win_d;
      vc_q <= vc_d;
      bc_q <= bc_d;
      cnt_q <= cnt_d;
      hit_q <= match;
    end
  end
  assign gnt = gnt_q;
  assign busy = state_q != IDLE;
  assign hit = hit_q;
  assign done = state_q == DONE;
  assign done_id = done && lp_q;
  assign cnt = cnt_q;
endmodule

// File: tb/tb_snail_scan_arbiter.sv
// tb_snail_scan_arbiter: scoreboard bench for snail_scan_arbiter with directed vectors
module tb_snail_scan_arbiter;
  localparam int W = 8;
  localparam int CNT_W = 4;
  typedef struct {
    logic [1:0] g;
    logic id;
    logic [CNT_W-1:0] c;
    logic [W-1:0] m;
    int gap;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic [2:0] pat = '0;
  logic [1:0] gnt;
  logic busy, hit, done, done_id;
  logic [CNT_W-1:0] cnt;
  logic chk_rst = 1'b0, tmo = 1'b0;
  exp_t q[$];
  int total = 0, bad = 0;
  snail_scan_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .pat(pat),
    .gnt(gnt), .busy(busy), .hit(hit), .done(done), .done_id(done_id), .cnt(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, want);
    end
  endtask
  initial begin
    int cyc, idle, gap;
    logic [W-1:0] hm;
    logic [1:0] gv;
    logic ins;
    exp_t e;
    cyc = 0; idle = 0; gap = 0; hm = '0; gv = '0; ins = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_rst) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_cnt", cnt, 0);
      end
      if (tmo) chk("timeout", 1, 0);
      if (gnt == 2'b00) begin
        ins = 1'b0;
        idle++;
        if (done) chk("done_without_gnt", 1, 0);
        if (hit && !rst) chk("hit_while_idle", 1, 0);
      end else begin
        if (!ins) begin
          ins = 1'b1; cyc = 0; hm = '0; gv = gnt; gap = idle;
        end else cyc++;
        if (gnt != gv) chk("gnt_stable", gnt, gv);
        if (hit) begin
          if (cyc >= 2 && cyc <= W + 1) hm[cyc-2] = 1'b1;
          else chk("hit_position", cyc, 2);
        end
        if (done) begin
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("gnt", gv, e.g);
            chk("done_id", done_id, e.id);
            chk("cnt", cnt, e.c);
            chk("hit_mask", hm, e.m);
            chk("gnt_len", cyc + 1, W + 3);
            chk("busy", busy, 1);
            if (e.gap >= 0) chk("idle_gap", gap, e.gap);
          end
          idle = 0;
          ins = 1'b0;
        end
      end
    end
  end
  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      q.delete();
      tmo = 1'b1;
      @(negedge clk);
      #1 tmo = 1'b0;
    end
  endtask
  task automatic serve(input logic [1:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] p, input exp_t e);
    req = r; data0 = a; data1 = b; pat = p;
    q.push_back(e);
    wait_empty();
    req = 2'b00;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
  endtask
  initial begin
    do_reset();
    @(posedge clk);
    #1;
    serve(2'b01, 8'b11011011, 8'h00, 3'b110, '{g:2'b01, id:1'b0, c:4'd2, m:8'b00100100, gap:-1});
    serve(2'b10, 8'h00, 8'b00000110, 3'b110, '{g:2'b10, id:1'b1, c:4'd1, m:8'b10000000, gap:-1});
    serve(2'b01, 8'hFF, 8'h00, 3'b111, '{g:2'b01, id:1'b0, c:4'd6, m:8'b11111100, gap:-1});
    serve(2'b01, 8'h00, 8'hFF, 3'b000, '{g:2'b01, id:1'b0, c:4'd6, m:8'b11111100, gap:-1});
    do_reset();
    @(posedge clk);
    #1;
    req = 2'b11; data0 = 8'b11011011; data1 = 8'b00000110; pat = 3'b110;
    q.push_back('{g:2'b01, id:1'b0, c:4'd2, m:8'b00100100, gap:-1});
    q.push_back('{g:2'b10, id:1'b1, c:4'd1, m:8'b10000000, gap:1});
    q.push_back('{g:2'b01, id:1'b0, c:4'd2, m:8'b00100100, gap:1});
    q.push_back('{g:2'b10, id:1'b1, c:4'd1, m:8'b10000000, gap:1});
    wait_empty();
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    req = 2'b01; data0 = 8'b11011011; pat = 3'b110;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 2'b11;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    q.push_back('{g:2'b01, id:1'b0, c:4'd2, m:8'b00100100, gap:-1});
    wait_empty();
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    req = 2'b01; data0 = 8'b11011011; data1 = 8'h00; pat = 3'b110;
    q.push_back('{g:2'b01, id:1'b0, c:4'd2, m:8'b00100100, gap:-1});
    repeat (4) @(posedge clk);
    #1;
    pat = 3'b111; data0 = 8'hFF; req = 2'b00;
    wait_empty();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
